// File: rtl/fixed_point_sqrt_iter.sv
// rtl/fixed_point_sqrt_iter.sv - multi-cycle unsigned Q(I.F) square root, one root bit per cycle
//
// Restoring digit-by-digit square root with valid/ready handshakes on both sides.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   operand valid
//   in_ready_o   operand can be accepted (IDLE only)
//   num_i        radicand, unsigned Q(I.F)
//   out_valid_o  result valid, held until out_ready_i
//   out_ready_i  consumer accepts result
//   sqrt_o       root, unsigned Q(I.F)
//   exact_o      final remainder was zero
//   busy_o       operation in flight (CALC or DONE)
module fixed_point_sqrt_iter #(
    parameter int INTEGER_WIDTH  = 8,
    parameter int FRACTION_WIDTH = 8,
    parameter int ROUND          = 0,
    localparam int W             = INTEGER_WIDTH + FRACTION_WIDTH
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] num_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] sqrt_o,
    output logic         exact_o,
    output logic         busy_o
);

    // Radicand is {num, F zeros}, padded to an even width so it splits into bit pairs.
    localparam int NRAW = INTEGER_WIDTH + 2 * FRACTION_WIDTH;
    localparam int N    = NRAW + (NRAW % 2);
    localparam int ITER = N / 2;
    localparam int RW   = ITER + 2;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          state_q;
    logic [N-1:0]    rad_q;
    logic [ITER-1:0] q_q;
    logic [RW-1:0]   rem_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    sqrt_q;
    logic            exact_q;
    logic            out_valid_q;

    logic [N-1:0]    rad_init;
    logic [N-1:0]    rad_d;
    logic [RW+1:0]   rem_shift;
    logic [RW+1:0]   sub_val;
    logic [RW+1:0]   diff;
    logic            fit;
    logic [RW-1:0]   rem_d;
    logic [ITER-1:0] q_d;
    logic [W-1:0]    root_w;
    logic [W:0]      root_inc;
    logic            round_up;
    logic [W-1:0]    result_d;

    always_comb begin
        rad_init          = '0;
        rad_init[W-1:0]   = num_i;
        rad_init          = rad_init << FRACTION_WIDTH;
        rad_d             = rad_q << 2;

        // Bring down the next two radicand bits and try subtracting 4q+1.
        rem_shift = {rem_q, rad_q[N-1:N-2]};
        sub_val   = RW'({q_q, 2'b01});
        fit       = (rem_shift >= sub_val);
        diff      = rem_shift - sub_val;
        rem_d     = RW'(fit ? diff : rem_shift);
        q_d       = ITER'({q_q, fit});

        // Round to nearest: sqrt(R) >= q + 1/2 exactly when rem > q (ties are impossible).
        root_w    = W'(q_d);
        root_inc  = {1'b0, root_w} + (W + 1)'(1);
        round_up  = (ROUND != 0) && (rem_d > RW'(q_d));
        result_d  = root_w;
        if (round_up) begin
            result_d = root_inc[W] ? '1 : root_inc[W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            rad_q       <= '0;
            q_q         <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            sqrt_q      <= '0;
            exact_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i) begin
                        rad_q   <= rad_init;
                        q_q     <= '0;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    rad_q <= rad_d;
                    q_q   <= q_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(ITER - 1)) begin
                        sqrt_q      <= result_d;
                        exact_q     <= (rem_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign out_valid_o = out_valid_q;
    assign sqrt_o      = sqrt_q;
    assign exact_o     = exact_q;

endmodule
